// File: rtl/draw_pkg.sv
// Shared types and constants for the shot draw queue: command payload, colours, FSM states.
package draw_pkg;

  localparam int unsigned COORD_W  = 4;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_HIT  = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_MISS = 3'b111;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               player;
    logic               hit;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } drawq_state_e;

endpackage

// File: rtl/shot_draw_queue_if.sv
// Command intake and drawing-engine handshake bundle; slave = the queue, master = its environment.
interface shot_draw_queue_if;
  import draw_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic                cmd_player;
  logic                cmd_hit;

  logic                draw_start;
  logic [COORD_W-1:0]  draw_x;
  logic [COORD_W-1:0]  draw_y;
  logic                draw_player;
  logic [COLOUR_W-1:0] draw_colour;
  logic                draw_done;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_player, cmd_hit, draw_done,
    output cmd_ready, draw_start, draw_x, draw_y, draw_player, draw_colour
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_player, cmd_hit, draw_done,
    input  cmd_ready, draw_start, draw_x, draw_y, draw_player, draw_colour
  );
endinterface

// File: rtl/draw_fifo.sv
// Power-of-two command FIFO with extra-MSB pointers; head is presented combinationally on rdata.
module draw_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  draw_cmd_t              wdata,
  input  logic                   pop,
  output draw_cmd_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  draw_cmd_t     mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/shot_draw_queue.sv
// Queues draw commands and issues them one at a time over a level start/done handshake.
// Optional drop statistics counter enabled by defining SHOT_DRAW_QUEUE_STATS_EN.
module shot_draw_queue
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GRID  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shot_draw_queue_if.slave       bus,
  input  logic                   board_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   busy
`ifdef SHOT_DRAW_QUEUE_STATS_EN
  ,
  output logic [7:0]             drop_count
`endif
);

  drawq_state_e        state_q;
  drawq_state_e        state_d;
  draw_cmd_t           head;
  draw_cmd_t           wcmd;
  logic                full;
  logic                empty;
  logic                in_range;
  logic                accept;
  logic                push;
  logic                pop;

  logic                draw_start_q;
  logic [COORD_W-1:0]  draw_x_q;
  logic [COORD_W-1:0]  draw_y_q;
  logic                draw_player_q;
  logic [COLOUR_W-1:0] draw_colour_q;

  assign wcmd     = '{x: bus.cmd_x, y: bus.cmd_y, player: bus.cmd_player, hit: bus.cmd_hit};
  assign in_range = (32'(bus.cmd_x) < GRID) && (32'(bus.cmd_y) < GRID);
  assign accept   = bus.cmd_valid && !full;
  // Out-of-range commands still complete the handshake but never reach the FIFO.
  assign push     = accept && in_range;

  draw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and pop decision; board_ready only matters when starting a new command.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (board_ready && !empty && !bus.draw_done) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.draw_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.draw_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_start_q  <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_player_q <= 1'b0;
      draw_colour_q <= '0;
    end else begin
      draw_start_q <= (state_d == S_ISSUE);
      if (pop) begin
        draw_x_q      <= head.x;
        draw_y_q      <= head.y;
        draw_player_q <= head.player;
        draw_colour_q <= head.hit ? COLOUR_HIT : COLOUR_MISS;
      end
    end
  end

`ifdef SHOT_DRAW_QUEUE_STATS_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   drop_cnt_q <= '0;
    else if (accept && !in_range && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign bus.cmd_ready   = !full;
  assign bus.draw_start  = draw_start_q;
  assign bus.draw_x      = draw_x_q;
  assign bus.draw_y      = draw_y_q;
  assign bus.draw_player = draw_player_q;
  assign bus.draw_colour = draw_colour_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_shot_draw_queue.sv
// Directed self-checking bench for shot_draw_queue; inputs change on negedge, outputs sampled on negedge.
module tb_shot_draw_queue;

  logic       clk;
  logic       rst_n;
  logic       board_ready;
  logic [3:0] occupancy;
  logic       busy;
`ifdef SHOT_DRAW_QUEUE_STATS_EN
  logic [7:0] drop_count;
`endif

  int checks;
  int passed;

  shot_draw_queue_if bus ();

  shot_draw_queue #(.DEPTH(8), .GRID(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .board_ready (board_ready),
    .occupancy   (occupancy),
    .busy        (busy)
`ifdef SHOT_DRAW_QUEUE_STATS_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] x, input logic [3:0] y, input logic p, input logic h);
    bus.cmd_valid  = 1'b1;
    bus.cmd_x      = x;
    bus.cmd_y      = y;
    bus.cmd_player = p;
    bus.cmd_hit    = h;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL rst_draw_start got %b want 0", bus.draw_start); else passed++;
    checks++; if (bus.draw_x !== 4'd0 || bus.draw_y !== 4'd0 || bus.draw_player !== 1'b0)
      $display("FAIL rst_draw_xyp got %0d,%0d,%b want 0,0,0", bus.draw_x, bus.draw_y, bus.draw_player); else passed++;
    checks++; if (bus.draw_colour !== 3'b000) $display("FAIL rst_colour got %b want 000", bus.draw_colour); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
`ifdef SHOT_DRAW_QUEUE_STATS_EN
    checks++; if (drop_count !== 8'd0) $display("FAIL rst_drop_count got %0d want 0", drop_count); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", bus.cmd_ready); else passed++;
    checks++; if (occupancy !== 4'd0) $display("FAIL rst_occupancy got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_single();
    board_ready   = 1'b1;
    bus.draw_done = 1'b0;
    push(4'd3, 4'd7, 1'b1, 1'b1);
    checks++; if (occupancy !== 4'd1) $display("FAIL single_occ_after_push got %0d want 1", occupancy); else passed++;
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL single_start_early got %b want 0", bus.draw_start); else passed++;
    tick();
    checks++; if (bus.draw_start !== 1'b1) $display("FAIL single_start got %b want 1", bus.draw_start); else passed++;
    checks++; if (bus.draw_x !== 4'd3 || bus.draw_y !== 4'd7 || bus.draw_player !== 1'b1)
      $display("FAIL single_xyp got %0d,%0d,%b want 3,7,1", bus.draw_x, bus.draw_y, bus.draw_player); else passed++;
    checks++; if (bus.draw_colour !== 3'b100) $display("FAIL single_colour got %b want 100", bus.draw_colour); else passed++;
    checks++; if (occupancy !== 4'd0 || busy !== 1'b1) $display("FAIL single_occ_busy got %0d,%b want 0,1", occupancy, busy); else passed++;
    bus.draw_done = 1'b1;
    tick();
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL single_start_drop got %b want 0", bus.draw_start); else passed++;
    bus.draw_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_fill();
    board_ready   = 1'b1;
    bus.draw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_x      = 4'(i);
      bus.cmd_y      = 4'(i);
      bus.cmd_player = 1'b0;
      bus.cmd_hit    = 1'(i);
      if (i == 9) begin
        checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL fill_ready_before_10th got %b want 0", bus.cmd_ready); else passed++;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++; if (occupancy !== 4'd8) $display("FAIL fill_occupancy got %0d want 8", occupancy); else passed++;
    checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", bus.cmd_ready); else passed++;
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd0)
      $display("FAIL fill_in_flight got start=%b x=%0d want 1,0", bus.draw_start, bus.draw_x); else passed++;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
    tick();
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd1 || bus.draw_colour !== 3'b100)
      $display("FAIL fill_second got start=%b x=%0d col=%b want 1,1,100", bus.draw_start, bus.draw_x, bus.draw_colour); else passed++;
    checks++; if (occupancy !== 4'd7 || bus.cmd_ready !== 1'b1)
      $display("FAIL fill_after_pop got occ=%0d ready=%b want 7,1", occupancy, bus.cmd_ready); else passed++;
    // Reset while a command is in flight.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL midrst_start got %b want 0", bus.draw_start); else passed++;
    checks++; if (occupancy !== 4'd0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_state got occ=%0d ready=%b busy=%b want 0,1,0", occupancy, bus.cmd_ready, busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.draw_start !== 1'b0 || occupancy !== 4'd0)
      $display("FAIL midrst_after got start=%b occ=%0d want 0,0", bus.draw_start, occupancy); else passed++;
  endtask

  task automatic test_gating();
    board_ready   = 1'b0;
    bus.draw_done = 1'b0;
    push(4'd1, 4'd2, 1'b0, 1'b0);
    push(4'd4, 4'd5, 1'b1, 1'b1);
    tick();
    tick();
    checks++; if (bus.draw_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL gate_held got start=%b busy=%b want 0,0", bus.draw_start, busy); else passed++;
    checks++; if (occupancy !== 4'd2) $display("FAIL gate_occ got %0d want 2", occupancy); else passed++;
    board_ready = 1'b1;
    tick();
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd1 || bus.draw_y !== 4'd2 || bus.draw_colour !== 3'b111)
      $display("FAIL gate_first got start=%b x=%0d y=%0d col=%b want 1,1,2,111",
               bus.draw_start, bus.draw_x, bus.draw_y, bus.draw_colour); else passed++;
    checks++; if (occupancy !== 4'd1) $display("FAIL gate_occ_after got %0d want 1", occupancy); else passed++;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
    tick();
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd4 || bus.draw_player !== 1'b1 || bus.draw_colour !== 3'b100)
      $display("FAIL gate_second got start=%b x=%0d p=%b col=%b want 1,4,1,100",
               bus.draw_start, bus.draw_x, bus.draw_player, bus.draw_colour); else passed++;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
  endtask

  task automatic test_range();
    board_ready   = 1'b1;
    bus.draw_done = 1'b0;
    push(4'd10, 4'd0, 1'b0, 1'b1);
    checks++; if (occupancy !== 4'd0 || bus.cmd_ready !== 1'b1)
      $display("FAIL range_drop_x got occ=%0d ready=%b want 0,1", occupancy, bus.cmd_ready); else passed++;
    push(4'd9, 4'd9, 1'b0, 1'b0);
    checks++; if (occupancy !== 4'd1) $display("FAIL range_keep_occ got %0d want 1", occupancy); else passed++;
    tick();
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd9 || bus.draw_y !== 4'd9 || bus.draw_colour !== 3'b111)
      $display("FAIL range_issue got start=%b x=%0d y=%0d col=%b want 1,9,9,111",
               bus.draw_start, bus.draw_x, bus.draw_y, bus.draw_colour); else passed++;
`ifdef SHOT_DRAW_QUEUE_STATS_EN
    checks++; if (drop_count !== 8'd1) $display("FAIL range_drop_count1 got %0d want 1", drop_count); else passed++;
`endif
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
    push(4'd2, 4'd15, 1'b1, 1'b1);
    tick();
    checks++; if (occupancy !== 4'd0 || bus.draw_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL range_drop_y got occ=%0d start=%b busy=%b want 0,0,0", occupancy, bus.draw_start, busy); else passed++;
`ifdef SHOT_DRAW_QUEUE_STATS_EN
    checks++; if (drop_count !== 8'd2) $display("FAIL range_drop_count2 got %0d want 2", drop_count); else passed++;
`endif
  endtask

  task automatic test_handshake();
    board_ready   = 1'b1;
    bus.draw_done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 4'd5; bus.cmd_y = 4'd5; bus.cmd_player = 1'b0; bus.cmd_hit = 1'b1;
    tick();
    bus.cmd_x = 4'd6; bus.cmd_y = 4'd6; bus.cmd_player = 1'b1; bus.cmd_hit = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd5 || occupancy !== 4'd1)
      $display("FAIL hs_first got start=%b x=%0d occ=%0d want 1,5,1", bus.draw_start, bus.draw_x, occupancy); else passed++;
    bus.draw_done = 1'b1;
    tick();
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL hs_start_drop got %b want 0", bus.draw_start); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.draw_start !== 1'b0 || occupancy !== 4'd1)
        $display("FAIL hs_hold%0d got start=%b occ=%0d want 0,1", i, bus.draw_start, occupancy); else passed++;
    end
    bus.draw_done = 1'b0;
    tick();
    checks++; if (bus.draw_start !== 1'b0) $display("FAIL hs_release got %b want 0", bus.draw_start); else passed++;
    tick();
    checks++; if (bus.draw_start !== 1'b1 || bus.draw_x !== 4'd6 || bus.draw_player !== 1'b1 || bus.draw_colour !== 3'b111)
      $display("FAIL hs_second got start=%b x=%0d p=%b col=%b want 1,6,1,111",
               bus.draw_start, bus.draw_x, bus.draw_player, bus.draw_colour); else passed++;
    checks++; if (occupancy !== 4'd0) $display("FAIL hs_occ got %0d want 0", occupancy); else passed++;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    tick();
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    rst_n          = 1'b1;
    board_ready    = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_x      = 4'd0;
    bus.cmd_y      = 4'd0;
    bus.cmd_player = 1'b0;
    bus.cmd_hit    = 1'b0;
    bus.draw_done  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_reset();
    test_gating();
    test_reset();
    test_range();
    test_reset();
    test_handshake();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
